// File: rtl/score_keeper.sv
// score_keeper: game-score engine feeding the seven-segment stage.
// Counts run distance in packed BCD at a fixed tick rate during play.
// Freezes the score on crash and keeps the session high score.
// Emits a 100-point milestone pulse and a saturating 2-bit speed level.
module score_keeper #(
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned LEVEL_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        crash,
    input  logic        restart,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic        milestone,
    output logic [1:0]  level,
    output logic        game_over
);

    localparam int unsigned        PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [1:0]         LEVEL_TOP = 2'(LEVEL_MAX);
    localparam logic [15:0]        SCORE_TOP = 16'h9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PRE_W-1:0] prescaler, prescaler_nxt;
    logic [15:0]      score_nxt;
    logic [15:0]      hi_score_nxt;
    logic [15:0]      score_inc;
    logic [1:0]       level_nxt;
    logic             milestone_nxt;
    logic             tick;

    // Packed-BCD +1: each nibble wraps 9->0 and carries into the next one,
    // so every digit stays in 0..9 without a binary intermediate.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (result[4*d +: 4] == 4'd9) begin
                    result[4*d +: 4] = 4'd0;
                end else begin
                    result[4*d +: 4] = result[4*d +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

    assign score_inc = bcd_inc(score);
    assign tick      = (prescaler == PRE_LAST);

    // Next-state and next-output logic; restart beats crash beats tick.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt     = state;
        prescaler_nxt = prescaler;
        score_nxt     = score;
        hi_score_nxt  = hi_score;
        level_nxt     = level;
        milestone_nxt = 1'b0;

        if (restart) begin
            state_nxt     = IDLE;
            prescaler_nxt = '0;
            score_nxt     = '0;
            level_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    prescaler_nxt = '0;
                    score_nxt     = '0;
                    if (run) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (crash) begin
                        // Crash wins over a coincident tick: compare the
                        // pre-tick score and freeze everything.
                        state_nxt = OVER;
                        if (score > hi_score) begin
                            hi_score_nxt = score;
                        end
                    end else if (run) begin
                        if (tick) begin
                            prescaler_nxt = '0;
                            if (score != SCORE_TOP) begin
                                score_nxt = score_inc;
                                if (score_inc[7:0] == 8'h00) begin
                                    milestone_nxt = 1'b1;
                                    if (level < LEVEL_TOP) begin
                                        level_nxt = level + 2'd1;
                                    end
                                end
                            end
                        end else begin
                            prescaler_nxt = prescaler + 1'b1;
                        end
                    end
                end
                OVER: begin
                    // Frozen until restart; run and crash have no effect.
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            score     <= '0;
            hi_score  <= '0;
            level     <= '0;
            milestone <= 1'b0;
            game_over <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the same pre-edge values, independent of statement order.
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            score     <= score_nxt;
            hi_score  <= hi_score_nxt;
            level     <= level_nxt;
            milestone <= milestone_nxt;
            game_over <= (state_nxt == OVER);
        end
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-score engine that produces the value shown on the seven-segment display stage; sits directly upstream of seven_segment.
- Counts run distance in packed BCD at a fixed tick rate while the game FSM is in play.
- Freezes the score on crash and tracks the session high score.
- Emits a one-cycle milestone pulse every 100 points and a 2-bit speed level for the game FSM and pixel generator.

Parameters:
- TICK_DIV, 10_000_000, clk cycles per score point (10 points/s at 100 MHz); legal range ≥2.
- LEVEL_MAX, 3, saturation value of level output.

Ports:
- clk  input  1  system clock (100 MHz board clock)
- reset  input  1  asynchronous, active-high reset
- run  input  1  level; 1 while the game FSM is in its play state
- crash  input  1  one-cycle pulse; collision detected
- restart  input  1  one-cycle pulse; new game requested
- score  output  16  current score, packed BCD {thousands, hundreds, tens, units}
- hi_score  output  16  session high score, packed BCD
- milestone  output  1  one-cycle pulse when score crosses a multiple of 100
- level  output  2  speed level, +1 per milestone, saturating at LEVEL_MAX
- game_over  output  1  high while in OVER state

Behaviour:
- Reset (async, active-high):
  - state=IDLE; prescaler=0.
  - score=16'h0000, hi_score=16'h0000, milestone=0, level=0, game_over=0.
- States:
  - IDLE:
    - score held at 0, prescaler held at 0.
    - run=1 → RUN on the next edge.
  - RUN:
    - While run=1, prescaler counts 0..TICK_DIV-1 and wraps.
    - When prescaler==TICK_DIV-1, the score increments by 1 (BCD) on that edge.
    - run=0 pauses: prescaler and score hold, state stays RUN.
    - crash → OVER.
  - OVER:
    - game_over=1; score, prescaler and level are frozen.
    - run and crash are ignored.
- BCD increment:
  - Per-digit carry chain: a digit at 9 becomes 0 and carries into the next digit.
  - No binary intermediate; every digit is always in 0..9.
- Saturation: at 16'h9999 the score holds and no further milestone is produced.
- Milestone:
  - Asserted for exactly one cycle, in the same cycle the incremented score becomes visible, when the new score has tens=0 and units=0 (e.g. 0x0099→0x0100).
  - On each milestone, level increments unless it is already LEVEL_MAX.
- High score:
  - On the RUN→OVER edge, hi_score ← score if score > hi_score.
  - BCD magnitude compare equals unsigned compare of the packed 16-bit value.
  - hi_score is cleared only by reset.
- Priority within one cycle: restart > crash > tick.
  - restart in any state → IDLE next edge; score=0, prescaler=0, level=0, milestone=0, game_over=0; hi_score unchanged.
  - crash coincident with a tick: no increment. The hi_score compare uses the pre-tick score; no milestone.
  - restart coincident with crash: hi_score is NOT updated.
- Latency:
  - score is registered; it changes one edge after the terminal prescaler count.
  - game_over rises one edge after crash.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan (TICK_DIV=4 in simulation):
1. Reset behaviour:
   - Assert reset asynchronously mid-RUN with score=0x0042 → score, hi_score, level, game_over and milestone all 0 immediately, without waiting for a clk edge.
   - After release with run=0, state stays IDLE.
2. Basic counting:
   - run=1 held → score steps every 4 cycles: 0x0001, 0x0002…
   - After 10 ticks, score=0x0010.
   - Drop run for 20 cycles → score stays 0x0010.
   - Raise run again → counting resumes without losing the partial prescaler count.
3. BCD carry and milestone:
   - Run to 0x0099, next tick → score=0x0100, milestone=1 for exactly one cycle, level=1.
   - Continue to 0x0400 → level=3.
   - At 0x0500 → milestone pulses, level stays 3.
4. Crash coincident with tick:
   - At score 0x0123, pulse crash on the terminal prescaler cycle → score stays 0x0123, game_over=1 next edge, hi_score=0x0123.
   - 40 further cycles with run=1 → no change.
5. Restart and high-score retention:
   - restart → score=0, level=0, game_over=0, hi_score=0x0123.
   - Second game crashes at 0x0050 → hi_score remains 0x0123.
   - Third game crashes at 0x0200 → hi_score=0x0200.
6. Saturation and priority:
   - Preload near 0x9998 via forced run; counting goes 0x9998→0x9999, then holds with no milestone.
   - restart and crash in the same cycle → IDLE, score=0, hi_score unchanged.
